// File: rtl/div2_pkg.sv
// rtl/div2_pkg.sv - shared states and constants for the program-2 divide engine
package div2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_HI,
    RD_LO,
    RD_DIV,
    DIVIDE,
    WR0,
    WR1,
    WR2,
    DONE
  } div2_state_t;

  localparam int          Q_W         = 24;
  localparam int          FRAC_BITS   = 8;
  localparam int          DIV_ITERS   = 24;
  localparam int          LAT_NZ      = 30;
  localparam int          LAT_Z       = 6;
  localparam logic [23:0] DIV0_RESULT = 24'hFFFFFF;

endpackage

// File: rtl/restoring_div_step.sv
// rtl/restoring_div_step.sv - one compare/subtract iteration of a restoring divider
module restoring_div_step (
  input  logic [8:0] rem,
  input  logic       num_bit,
  input  logic [7:0] divisor,
  output logic [8:0] rem_next,
  output logic       q_bit
);

  logic [9:0] trial;
  logic [8:0] diff;

  // Shift the next numerator bit into the partial remainder and subtract if it fits.
  // The remainder stays below the divisor, so the 9-bit difference cannot wrap when taken.
  always_comb begin
    trial    = {rem, num_bit};
    diff     = trial[8:0] - {1'b0, divisor};
    q_bit    = (trial >= {2'b00, divisor});
    rem_next = q_bit ? diff : trial[8:0];
  end

endmodule

// File: rtl/div2_engine.sv
// rtl/div2_engine.sv - start/ack responder computing floor(dividend*256/divisor) in memory
module div2_engine
  import div2_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int OP_HI_ADDR   = 0,
  parameter int OP_LO_ADDR   = 1,
  parameter int DIVISOR_ADDR = 2,
  parameter int RES_ADDR     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        mem_wr_data,
  output logic              mem_wr_en
);

  div2_state_t    state, state_n;
  logic           start_q;
  logic [7:0]     div_hi, div_lo, divisor;
  logic [Q_W-1:0] num, q;
  logic [8:0]     rem, rem_next;
  logic [4:0]     cnt;
  logic           q_bit;
  logic           launch;

  assign launch = start_q & ~start;

  restoring_div_step u_step (
    .rem      (rem),
    .num_bit  (num[cnt]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state plus memory address/write strobes decoded from the current state.
  always_comb begin
    state_n     = state;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    case (state)
      IDLE, DONE: if (launch) state_n = RD_HI;
      RD_HI: begin
        mem_addr = ADDR_W'(OP_HI_ADDR);
        state_n  = RD_LO;
      end
      RD_LO: begin
        mem_addr = ADDR_W'(OP_LO_ADDR);
        state_n  = RD_DIV;
      end
      RD_DIV: begin
        mem_addr = ADDR_W'(DIVISOR_ADDR);
        state_n  = (mem_rd_data == 8'h00) ? WR0 : DIVIDE;
      end
      DIVIDE: if (cnt == 5'd0) state_n = WR0;
      WR0: begin
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(RES_ADDR);
        mem_wr_data = q[23:16];
        state_n     = WR1;
      end
      WR1: begin
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(RES_ADDR + 1);
        mem_wr_data = q[15:8];
        state_n     = WR2;
      end
      WR2: begin
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(RES_ADDR + 2);
        mem_wr_data = q[7:0];
        state_n     = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Ack is high exactly while DONE; it drops on the launch edge out of DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack <= 1'b0;
    else       ack <= (state_n == DONE);
  end

  // Start edge detector; resets high so a start held low at reset release launches at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= start;
  end

  // Operand capture and the iterative divide, MSB of the quotient first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_hi  <= '0;
      div_lo  <= '0;
      divisor <= '0;
      num     <= '0;
      q       <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        RD_HI: div_hi <= mem_rd_data;
        RD_LO: div_lo <= mem_rd_data;
        RD_DIV: begin
          divisor <= mem_rd_data;
          if (mem_rd_data == 8'h00) begin
            q <= DIV0_RESULT;
          end else begin
            num <= {div_hi, div_lo, {FRAC_BITS{1'b0}}};
            q   <= '0;
            rem <= '0;
            cnt <= 5'(DIV_ITERS - 1);
          end
        end
        DIVIDE: begin
          rem    <= rem_next;
          q[cnt] <= q_bit;
          cnt    <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div2_engine.md
Name: div2_engine

Overview:
- Hardware responder for the program-2 start/ack protocol.
- After start is released, it reads a 16-bit dividend and an 8-bit divisor from data memory.
- It computes the unrounded 16.8 fixed-point quotient floor(dividend*256/divisor) with an iterative restoring divider, writes the 24-bit result back to memory, and raises ack.
- It sits beside the data memory as a drop-in accelerator for the CPU's program-2 path; the bench loads operands and checks results exactly as it does for the CPU.

Parameters:
- ADDR_W, 8, data-memory address width.
- OP_HI_ADDR, 0, address of dividend[15:8].
- OP_LO_ADDR, 1, address of dividend[7:0].
- DIVISOR_ADDR, 2, address of the 8-bit divisor.
- RES_ADDR, 4, result base: RES_ADDR gets q[23:16], +1 gets q[15:8], +2 gets q[7:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; high holds the block armed/idle; the high-to-low transition launches an operation.
- ack  out  1  registered; high while in DONE.
- mem_addr  out  ADDR_W  memory address, decoded from state.
- mem_rd_data  in  8  combinational read data for mem_addr; sampled at the clock edge.
- mem_wr_data  out  8  write data.
- mem_wr_en  out  1  synchronous write strobe; memory writes at the edge while high.

Behaviour:
- Reset values:
  - state=IDLE, ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - start_q (previous start) resets to 1, so a start held low at reset release launches at the first edge.
  - Datapath registers reset to 0.
- Launch: an edge with start_q=1 and start=0 while in IDLE or DONE moves the block to RD_HI and clears ack. Call this edge E0.
- States and transitions:
  - IDLE: waits for launch.
  - RD_HI: mem_addr=OP_HI_ADDR; latches the dividend high byte at E1.
  - RD_LO: mem_addr=OP_LO_ADDR; latches the dividend low byte at E2.
  - RD_DIV: mem_addr=DIVISOR_ADDR; latches the divisor at E3.
    - Divisor==0: q=24'hFFFFFF, next state WR0.
    - Otherwise: loads num={dividend,8'h00}, rem=9'd0, cnt=23, next state DIVIDE.
  - DIVIDE: one quotient bit per edge, MSB first.
    - t={rem[7:0],num[cnt]}; if t>=divisor then rem=t-divisor and q[cnt]=1, else rem=t and q[cnt]=0.
    - Runs 24 edges, E4..E27, then goes to WR0.
  - WR0/WR1/WR2: mem_wr_en=1, mem_addr=RES_ADDR+0/1/2, mem_wr_data=q[23:16]/q[15:8]/q[7:0]. Writes land at E28, E29, E30.
  - DONE: entered at E30; ack=1 from E30 until the next launch or reset.
- Latency: ack rises at E30 for a nonzero divisor and at E6 for a zero divisor.
- Width rules:
  - The remainder is 9 bits internally; the compare is unsigned.
  - The quotient is exactly floor(div_in*256/divisor) mod 2^24. It never overflows, since div_in<2^16.
- start edges while busy (RD_*, DIVIDE, WR*) are ignored. start_q still tracks start, so only a fall seen in IDLE/DONE launches.
- Start rising then falling while in DONE relaunches; ack drops at the launch edge.
- Reset mid-operation: immediate return to reset values. No further memory write occurs, and a partially written result is left as-is.
- mem_wr_en is never high outside WR0..WR2.
- Operands are read only after launch, so memory may be loaded in the same cycle that start falls.

Decomposition:
- Package div2_pkg holds:
  - state enum: IDLE, RD_HI, RD_LO, RD_DIV, DIVIDE, WR0, WR1, WR2, DONE.
  - constants: Q_W=24, FRAC_BITS=8, DIV_ITERS=24, LAT_NZ=30, LAT_Z=6, DIV0_RESULT=24'hFFFFFF.
- Sub-module restoring_div_step: combinational single-iteration compare/subtract.
  - Inputs: rem, next numerator bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once; the FSM and all registers stay in div2_engine.

Test Plan:
- Load core[0..2]=00,5A,05; release reset+start together -> ack at E30; core[4..6]=00,12,00 (4608); no writes before E28.
- Load core[0..2]=01,0E,0E (270/14) -> core[4..6]=00,13,49 (4937).
- Load core[0..2]=00,03,74 (3/116) -> core[4..6]=00,00,06; then load FF,FF,01 and relaunch via start pulse -> ack drops at the launch edge, core[4..6]=FF,FF,00.
- Divisor core[2]=00 with dividend 1234 -> ack at E6; core[4..6]=FF,FF,FF.
- Assert reset at E15 of a 90/5 run -> ack=0 and mem_wr_en=0 immediately; core[4..6] unchanged; a clean relaunch then gives 00,12,00.
- Toggle start high/low during DIVIDE -> ignored; result and ack timing identical to the undisturbed run.
